// File: rtl/data_mem_if.sv
// Load/store bus between the core's control unit (master) and the data memory (slave).
interface data_mem_if;
    logic [31:0] addr_i;
    logic        mem_r_en_i;
    logic        mem_r_sext_i;
    logic [1:0]  mem_acc_r_i;
    logic        mem_wr_en_i;
    logic [1:0]  mem_acc_w_i;
    logic [31:0] wr_data_i;
    logic [31:0] rd_data_o;
    logic        rd_valid_o;
    logic        mem_wr_ready_o;

    modport master (
        output addr_i, mem_r_en_i, mem_r_sext_i, mem_acc_r_i,
               mem_wr_en_i, mem_acc_w_i, wr_data_i,
        input  rd_data_o, rd_valid_o, mem_wr_ready_o
    );

    modport slave (
        input  addr_i, mem_r_en_i, mem_r_sext_i, mem_acc_r_i,
               mem_wr_en_i, mem_acc_w_i, wr_data_i,
        output rd_data_o, rd_valid_o, mem_wr_ready_o
    );
endinterface

// File: rtl/data_mem.sv
// Byte-addressed, little-endian data memory answering the core's load/store requests.
// Accesses straddling a 32-bit word boundary take two RAM cycles under a small FSM.
module data_mem #(
    parameter int    DEPTH     = 1024,
    parameter string INIT_FILE = ""
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    data_mem_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] ACC_BYTE = 2'd0;
    localparam logic [1:0] ACC_HALF = 2'd1;
    localparam logic [1:0] ACC_WORD = 2'd2;

    typedef enum logic [1:0] {ST_IDLE, ST_RD2, ST_WR2} state_e;

    logic [31:0] mem [DEPTH];

    state_e        state_q;
    logic [31:0]   rdData_q;
    logic          rdValid_q;
    logic [31:0]   lowWord_q;
    logic [31:0]   hiData_q;
    logic [3:0]    hiBe_q;
    logic [AW-1:0] hiIdx_q;
    logic [1:0]    rdOff_q;
    logic [1:0]    rdSize_q;
    logic          rdSext_q;

    logic [AW-1:0] idx;
    logic [AW-1:0] idxNext;
    logic [1:0]    off;
    logic          crossR;
    logic          crossW;
    logic [3:0]    sizeMask;
    logic [7:0]    beWide;
    logic [63:0]   dataWide;
    logic [31:0]   rdWordLo;
    logic [31:0]   rdWordHi;
    logic [31:0]   rdSplitRaw;
    logic [AW-1:0] wrIdx;
    logic [31:0]   wrData;
    logic [3:0]    wrBe;
    logic          unusedAddr;

    assign idx        = bus.addr_i[AW+1:2];
    assign idxNext    = idx + AW'(1);
    assign off        = bus.addr_i[1:0];
    assign unusedAddr = ^bus.addr_i[31:AW+2];

    assign crossR = (bus.mem_acc_r_i == ACC_HALF && off == 2'd3) ||
                    (bus.mem_acc_r_i == ACC_WORD && off != 2'd0);
    assign crossW = (bus.mem_acc_w_i == ACC_HALF && off == 2'd3) ||
                    (bus.mem_acc_w_i == ACC_WORD && off != 2'd0);

    always_comb begin
        case (bus.mem_acc_w_i)
            ACC_BYTE: sizeMask = 4'b0001;
            ACC_HALF: sizeMask = 4'b0011;
            ACC_WORD: sizeMask = 4'b1111;
            default:  sizeMask = 4'b0000;
        endcase
    end

    // Store data and byte enables laid out across two adjacent words; the upper half feeds the second cycle.
    assign beWide   = {4'b0000, sizeMask} << off;
    assign dataWide = {32'h0, bus.wr_data_i} << {off, 3'b000};

    assign rdWordLo   = mem[idx];
    assign rdWordHi   = mem[hiIdx_q];
    assign rdSplitRaw = 32'({rdWordHi, lowWord_q} >> {rdOff_q, 3'b000});

    function automatic logic [31:0] extend(input logic [31:0] raw,
                                           input logic [1:0]  size,
                                           input logic        sext);
        logic [31:0] res;
        case (size)
            ACC_BYTE: res = {{24{sext & raw[7]}}, raw[7:0]};
            ACC_HALF: res = {{16{sext & raw[15]}}, raw[15:0]};
            ACC_WORD: res = raw;
            default:  res = 32'h0;
        endcase
        return res;
    endfunction

    always_comb begin
        wrIdx  = idx;
        wrData = dataWide[31:0];
        wrBe   = 4'b0000;
        if (state_q == ST_WR2) begin
            wrIdx  = hiIdx_q;
            wrData = hiData_q;
            wrBe   = hiBe_q;
        end else if (state_q == ST_IDLE && bus.mem_wr_en_i) begin
            wrBe = beWide[3:0];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 4; k++) begin
            if (wrBe[k]) mem[wrIdx][8*k +: 8] <= wrData[8*k +: 8];
        end
    end

    // Writes take priority over reads; the second half of a split uses values captured at split start.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_IDLE;
            rdData_q  <= 32'h0;
            rdValid_q <= 1'b0;
            lowWord_q <= 32'h0;
            hiData_q  <= 32'h0;
            hiBe_q    <= 4'b0000;
            hiIdx_q   <= '0;
            rdOff_q   <= 2'd0;
            rdSize_q  <= 2'd0;
            rdSext_q  <= 1'b0;
        end else begin
            rdValid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.mem_wr_en_i) begin
                        if (crossW) begin
                            hiData_q <= dataWide[63:32];
                            hiBe_q   <= beWide[7:4];
                            hiIdx_q  <= idxNext;
                            state_q  <= ST_WR2;
                        end
                    end else if (bus.mem_r_en_i) begin
                        if (crossR) begin
                            lowWord_q <= rdWordLo;
                            hiIdx_q   <= idxNext;
                            rdOff_q   <= off;
                            rdSize_q  <= bus.mem_acc_r_i;
                            rdSext_q  <= bus.mem_r_sext_i;
                            state_q   <= ST_RD2;
                        end else begin
                            rdData_q  <= extend(rdWordLo >> {off, 3'b000},
                                                bus.mem_acc_r_i, bus.mem_r_sext_i);
                            rdValid_q <= 1'b1;
                        end
                    end
                end
                ST_RD2: begin
                    rdData_q  <= extend(rdSplitRaw, rdSize_q, rdSext_q);
                    rdValid_q <= 1'b1;
                    state_q   <= ST_IDLE;
                end
                ST_WR2: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_data_o      = rdData_q;
    assign bus.rd_valid_o     = rdValid_q;
    assign bus.mem_wr_ready_o = (state_q == ST_WR2) ||
                                (state_q == ST_IDLE && bus.mem_wr_en_i && !crossW);
endmodule

// File: tb/tb_data_mem.sv
// Directed and randomised checks of data_mem (DEPTH=16) against a byte-level memory model.
// Read results flow through an expected-value queue drained by a monitor on each rd_valid_o.
module tb_data_mem;
    logic clk  = 1'b0;
    logic rstn = 1'b0;

    data_mem_if bus ();

    data_mem #(.DEPTH(16), .INIT_FILE("")) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] expQ [$];
    logic [7:0]  model [64];
    logic [31:0] lastRd = 32'h0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic rEn, input logic sext,
                                 input logic [1:0] accR, input logic wEn, input logic [1:0] accW,
                                 input logic [31:0] wData);
        bus.addr_i       = addr;
        bus.mem_r_en_i   = rEn;
        bus.mem_r_sext_i = sext;
        bus.mem_acc_r_i  = accR;
        bus.mem_wr_en_i  = wEn;
        bus.mem_acc_w_i  = accW;
        bus.wr_data_i    = wData;
    endtask

    task automatic idleBus();
        applyStimulus(32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0);
    endtask

    function automatic logic isCross(input logic [1:0] off, input logic [1:0] size);
        return (size == 2'd1 && off == 2'd3) || (size == 2'd2 && off != 2'd0);
    endfunction

    function automatic int sizeBytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    endfunction

    function automatic logic [31:0] expRead(input logic [31:0] addr, input logic [1:0] size,
                                            input logic sext);
        logic [31:0] raw;
        raw = 32'h0;
        for (int k = 0; k < sizeBytes(size); k++) raw[8*k +: 8] = model[6'(addr + 32'(k))];
        if (size == 2'd0 && sext && raw[7])  raw = raw | 32'hFFFF_FF00;
        if (size == 2'd1 && sext && raw[15]) raw = raw | 32'hFFFF_0000;
        return raw;
    endfunction

    task automatic modelWrite(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
        for (int k = 0; k < sizeBytes(size); k++) model[6'(addr + 32'(k))] = data[8*k +: 8];
    endtask

    // Every rd_valid_o pulse must match the oldest outstanding expected read.
    always @(posedge clk) begin
        #1;
        if (rstn && bus.rd_valid_o === 1'b1) begin
            if (expQ.size() == 0) checkOutput("unexpected rd_valid", 32'd1, 32'd0);
            else                  checkOutput("rd_data", bus.rd_data_o, expQ.pop_front());
        end
    end

    task automatic doRead(input logic [31:0] addr, input logic [1:0] size, input logic sext,
                          input logic [31:0] exp);
        logic split;
        split = isCross(addr[1:0], size);
        @(negedge clk);
        applyStimulus(addr, 1'b1, sext, size, 1'b0, 2'd0, 32'h0);
        expQ.push_back(exp);
        @(negedge clk);
        idleBus();
        if (split) begin
            checkOutput("rd_valid early", {31'h0, bus.rd_valid_o}, 32'd0);
            @(negedge clk);
        end
        checkOutput("rd_valid", {31'h0, bus.rd_valid_o}, 32'd1);
        checkOutput("rd latency", 32'(expQ.size()), 32'd0);
        lastRd = exp;
        @(negedge clk);
        checkOutput("rd_valid pulse", {31'h0, bus.rd_valid_o}, 32'd0);
    endtask

    task automatic doWrite(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data,
                           input logic alsoRead);
        logic split;
        split = isCross(addr[1:0], size);
        @(negedge clk);
        applyStimulus(addr, alsoRead, 1'b0, 2'd2, 1'b1, size, data);
        #1 checkOutput("wr_ready first", {31'h0, bus.mem_wr_ready_o}, {31'h0, !split});
        if (split) begin
            @(negedge clk);
            #1 checkOutput("wr_ready second", {31'h0, bus.mem_wr_ready_o}, 32'd1);
        end
        modelWrite(addr, size, data);
        @(negedge clk);
        if (alsoRead) begin
            checkOutput("rw no rd_valid", {31'h0, bus.rd_valid_o}, 32'd0);
            checkOutput("rw rd_data held", bus.rd_data_o, lastRd);
        end
        idleBus();
        #1 checkOutput("wr_ready idle", {31'h0, bus.mem_wr_ready_o}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  s;
        logic        x;

        idleBus();
        repeat (2) @(negedge clk);
        checkOutput("reset rd_data", bus.rd_data_o, 32'h0);
        checkOutput("reset rd_valid", {31'h0, bus.rd_valid_o}, 32'd0);
        checkOutput("reset wr_ready", {31'h0, bus.mem_wr_ready_o}, 32'd0);
        rstn = 1'b1;

        for (int i = 0; i < 16; i++) doWrite(32'(4*i), 2'd2, 32'h1020_3040 + 32'(i) * 32'h0101_0101, 1'b0);

        // Byte store then signed/unsigned loads; neighbouring bytes survive.
        doWrite(32'h5, 2'd0, 32'h0000_0080, 1'b0);
        doRead(32'h5, 2'd0, 1'b1, 32'hFFFF_FF80);
        doRead(32'h5, 2'd0, 1'b0, 32'h0000_0080);
        doRead(32'h4, 2'd2, 1'b0, 32'h1121_8041);

        doWrite(32'h10, 2'd2, 32'hDEAD_BEEF, 1'b0);
        doRead(32'h10, 2'd2, 1'b1, 32'hDEAD_BEEF);
        doRead(32'h12, 2'd1, 1'b1, 32'hFFFF_DEAD);

        // Word write straddling words 0 and 1.
        doWrite(32'h0, 2'd2, 32'h0, 1'b0);
        doWrite(32'h4, 2'd2, 32'h0, 1'b0);
        doWrite(32'h2, 2'd2, 32'h1122_3344, 1'b0);
        doRead(32'h0, 2'd2, 1'b0, 32'h3344_0000);
        doRead(32'h4, 2'd2, 1'b0, 32'h0000_1122);
        doRead(32'h2, 2'd2, 1'b0, 32'h1122_3344);
        doRead(32'h3, 2'd1, 1'b1, 32'h0000_2233);

        // Half write at the top byte wraps into word 0.
        doWrite(32'h3F, 2'd1, 32'h0000_ABCD, 1'b0);
        doRead(32'h3F, 2'd0, 1'b0, 32'h0000_00CD);
        doRead(32'h0, 2'd0, 1'b0, 32'h0000_00AB);
        doRead(32'h100, 2'd0, 1'b1, 32'hFFFF_FFAB);
        doRead(32'h3F, 2'd1, 1'b0, 32'h0000_ABCD);

        // Reserved size: read returns zero, write is acknowledged but ignored.
        doRead(32'h8, 2'd3, 1'b1, 32'h0);
        doWrite(32'h8, 2'd3, 32'hFFFF_FFFF, 1'b0);
        doRead(32'h8, 2'd2, 1'b0, expRead(32'h8, 2'd2, 1'b0));

        doRead(32'h24, 2'd2, 1'b0, expRead(32'h24, 2'd2, 1'b0));
        // Reset lands while the second half of a split write is pending.
        @(negedge clk);
        applyStimulus(32'h21, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 32'hCAFE_F00D);
        #1 checkOutput("split wr_ready first", {31'h0, bus.mem_wr_ready_o}, 32'd0);
        @(negedge clk);
        #1 checkOutput("split wr_ready second", {31'h0, bus.mem_wr_ready_o}, 32'd1);
        rstn = 1'b0;
        idleBus();
        #1;
        checkOutput("midsplit rd_data", bus.rd_data_o, 32'h0);
        checkOutput("midsplit rd_valid", {31'h0, bus.rd_valid_o}, 32'd0);
        checkOutput("midsplit wr_ready", {31'h0, bus.mem_wr_ready_o}, 32'd0);
        for (int k = 0; k < 3; k++) model[6'(33 + k)] = 8'(32'hCAFE_F00D >> (8*k));
        lastRd = 32'h0;
        @(negedge clk);
        rstn = 1'b1;
        doWrite(32'h30, 2'd2, 32'h0BAD_CAFE, 1'b0);
        doRead(32'h20, 2'd2, 1'b0, expRead(32'h20, 2'd2, 1'b0));
        doRead(32'h24, 2'd2, 1'b0, expRead(32'h24, 2'd2, 1'b0));

        // Read and write together: only the write happens.
        doWrite(32'h18, 2'd2, 32'h55AA_55AA, 1'b1);
        doRead(32'h18, 2'd2, 1'b0, 32'h55AA_55AA);

        for (int i = 0; i < 24; i++) begin
            a = $urandom_range(0, 255);
            s = 2'($urandom_range(0, 3));
            x = 1'($urandom_range(0, 1));
            if (i % 3 == 0) doWrite(a, s, $urandom, 1'b0);
            else            doRead(a, s, x, expRead(a, s, x));
        end

        repeat (2) @(negedge clk);
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
